// File: rtl/rvc_fetch_ctrl_if.sv
// Fetch-side bus bundle: imem request/response, decoder handshake and redirect.
interface rvc_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  redirect;
  logic [31:0]           redirect_pc;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [31:0]           out_pc;
  logic                  out_is_comp;

  // Fetch controller side.
  modport master (
    input  redirect, redirect_pc, imem_dout, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, out_is_comp
  );

  // Memory/decoder/branch-unit side.
  modport slave (
    output redirect, redirect_pc, imem_dout, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, out_is_comp
  );
endinterface

// File: rtl/rvc_fetch_ctrl.sv
// RV32IC fetch controller: word-stream imem reads, 4-halfword realignment
// buffer, 16/32-bit instruction split, valid/ready output and PC redirect.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   FILL  | after reset/redirect; buffer empty, waiting for the first word
//   RUN   | steady streaming
module rvc_fetch_ctrl #(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  rvc_fetch_ctrl_if.master bus
);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            count_q, count_d;
  logic [3:0][15:0]      buf_q, buf_d;
  logic                  inflight_q, inflight_d;
  logic [31:0]           pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fa_q, fa_d;
  logic                  drop_low_q, drop_low_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic                  out_is_comp_q, out_is_comp_d;
  logic [31:0]           out_pc_q, out_pc_d;

  logic                  accept;
  logic [2:0]            pop_n;
  logic [2:0]            count_left;
  logic [3:0][15:0]      shifted;
  logic                  issue;
  logic                  push;
  logic                  drop;
  logic [15:0]           first_hw;
  logic                  comp_n;

  // Redirect PCs are halfword aligned; the LSB carries no information.
  logic                  unused_redirect_lsb;
  assign unused_redirect_lsb = bus.redirect_pc[0];

  // Next-state: pop, refill, push, redirect flush and the registered head view.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    buf_d         = buf_q;
    inflight_d    = inflight_q;
    pc_d          = pc_q;
    fa_d          = fa_q;
    drop_low_d    = drop_low_q;

    // The registered outputs mirror the buffer head, so they decide the pop size.
    accept     = out_valid_q && bus.out_ready && !bus.redirect;
    pop_n      = accept ? (out_is_comp_q ? 3'd1 : 3'd2) : 3'd0;
    count_left = count_q - pop_n;

    case (pop_n)
      3'd1:    shifted = {16'h0, buf_q[3], buf_q[2], buf_q[1]};
      3'd2:    shifted = {16'h0, 16'h0, buf_q[3], buf_q[2]};
      default: shifted = buf_q;
    endcase

    // A fresh word must always fit behind what is left plus what is in flight.
    issue    = ({1'b0, count_left} + {2'b00, inflight_q, 1'b0}) <= 4'd2;
    push     = inflight_q && !bus.redirect;
    drop     = (state_q == FILL) && drop_low_q;
    first_hw = drop ? bus.imem_dout[31:16] : bus.imem_dout[15:0];

    buf_d   = shifted;
    count_d = count_left;
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) == count_left) begin
          buf_d[i] = first_hw;
        end
        if (!drop && (3'(i) == (count_left + 3'd1))) begin
          buf_d[i] = bus.imem_dout[31:16];
        end
      end
      count_d    = count_left + (drop ? 3'd1 : 3'd2);
      state_d    = RUN;
      drop_low_d = 1'b0;
    end

    pc_d       = pc_q + {28'h0, pop_n, 1'b0};
    inflight_d = issue;
    fa_d       = issue ? (fa_q + ADDR_WIDTH'(1)) : fa_q;

    // Redirect wins over everything: the read issued this cycle (old fa) and
    // any response arriving now both belong to the discarded stream.
    if (bus.redirect) begin
      buf_d      = '0;
      count_d    = 3'd0;
      inflight_d = 1'b0;
      pc_d       = {bus.redirect_pc[31:1], 1'b0};
      fa_d       = bus.redirect_pc[ADDR_WIDTH+1:2];
      drop_low_d = bus.redirect_pc[1];
      state_d    = FILL;
    end

    // Head instruction as it will appear next cycle.
    comp_n        = buf_d[0][1:0] != 2'b11;
    out_valid_d   = comp_n ? (count_d != 3'd0) : (count_d >= 3'd2);
    out_is_comp_d = out_valid_d && comp_n;
    if (!out_valid_d) begin
      out_instr_d = 32'h0;
    end else if (comp_n) begin
      out_instr_d = {16'h0, buf_d[0]};
    end else begin
      out_instr_d = {buf_d[1], buf_d[0]};
    end
    out_pc_d = pc_d;
  end

  // State and output registers; reset clears everything, including inflight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      count_q       <= 3'd0;
      buf_q         <= '0;
      inflight_q    <= 1'b0;
      pc_q          <= RESET_PC;
      fa_q          <= RESET_PC[ADDR_WIDTH+1:2];
      drop_low_q    <= RESET_PC[1];
      out_valid_q   <= 1'b0;
      out_instr_q   <= 32'h0;
      out_is_comp_q <= 1'b0;
      out_pc_q      <= RESET_PC;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      buf_q         <= buf_d;
      inflight_q    <= inflight_d;
      pc_q          <= pc_d;
      fa_q          <= fa_d;
      drop_low_q    <= drop_low_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_is_comp_q <= out_is_comp_d;
      out_pc_q      <= out_pc_d;
    end
  end

  assign bus.imem_addr   = fa_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.out_is_comp = out_is_comp_q;
  assign bus.out_pc      = out_pc_q;

endmodule

// File: tb/tb_rvc_fetch_ctrl.sv
// Bench for rvc_fetch_ctrl: imem model, instruction-stream reference model,
// per-cycle compare and directed scenarios with literal expectations.
module tb_rvc_fetch_ctrl;
  localparam int          AW  = 11;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rvc_fetch_ctrl_if #(.ADDR_WIDTH(AW)) bus();

  rvc_fetch_ctrl #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:(1<<AW)-1];

  // Synchronous 1-cycle-latency instruction memory.
  always @(posedge clk) bus.imem_dout <= mem[bus.imem_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mpc;
  logic [31:0] acc_pc[$];
  logic [31:0] acc_instr[$];
  logic        acc_comp[$];
  int          acc_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[AW+1:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction starting at byte address a, as the decoder must see it.
  function automatic logic [31:0] model_instr(input logic [31:0] a);
    logic [15:0] h0;
    h0 = hw_at(a);
    if (h0[1:0] != 2'b11) return {16'h0, h0};
    return {hw_at(a + 32'd2), h0};
  endfunction

  function automatic logic [15:0] hwn(input int n);
    return {n[13:0], 2'b01};
  endfunction

  // Per-cycle compare against the model, then advance the model PC.
  always @(negedge clk) begin
    logic [31:0] e;
    logic        c;
    if (reset) begin
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_pc", bus.out_pc, RPC);
      mpc = RPC;
    end else begin
      e = model_instr(mpc);
      c = (e[1:0] != 2'b11);
      if (bus.out_valid) begin
        chk("cmp_pc", bus.out_pc, mpc);
        chk("cmp_instr", bus.out_instr, e);
        chk("cmp_comp", 32'(bus.out_is_comp), 32'(c));
      end
      if (bus.redirect) begin
        mpc = bus.redirect_pc & ~32'h1;
      end else if (bus.out_valid && bus.out_ready) begin
        acc_pc.push_back(bus.out_pc);
        acc_instr.push_back(bus.out_instr);
        acc_comp.push_back(bus.out_is_comp);
        acc_cyc.push_back(cyc);
        mpc = mpc + (c ? 32'd2 : 32'd4);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    acc_pc.delete();
    acc_instr.delete();
    acc_comp.delete();
    acc_cyc.delete();
  endtask

  // Holds reset for two edges with memory cleared; caller loads memory and releases.
  task automatic begin_test();
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready   = 1'b1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    step();
    step();
    clear_acc();
  endtask

  task automatic wait_acc(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (acc_pc.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(name, 32'(acc_pc.size() >= n), 32'd1);
  endtask

  initial begin
    logic [31:0] snap_pc, snap_instr;
    logic [AW-1:0] snap_addr;
    int n0;

    // Reset state.
    begin_test();
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_is_comp", 32'(bus.out_is_comp), 32'd0);

    // Aligned 32-bit stream.
    mem[0] = 32'h0000_0013; mem[1] = 32'h0010_0093; mem[2] = 32'h0020_0113;
    reset = 1'b0;
    step();
    chk("t1_valid_c1", 32'(bus.out_valid), 32'd0);
    step();
    chk("t1_valid_c2", 32'(bus.out_valid), 32'd1);
    wait_acc("t1_timeout", 3, 20);
    chk("t1_pc0", acc_pc[0], 32'h0);
    chk("t1_pc1", acc_pc[1], 32'h4);
    chk("t1_pc2", acc_pc[2], 32'h8);
    chk("t1_i0", acc_instr[0], 32'h0000_0013);
    chk("t1_i1", acc_instr[1], 32'h0010_0093);
    chk("t1_i2", acc_instr[2], 32'h0020_0113);
    chk("t1_comp", 32'({acc_comp[0], acc_comp[1], acc_comp[2]}), 32'd0);
    chk("t1_b2b_a", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    chk("t1_b2b_b", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);

    // Compressed pairs.
    begin_test();
    mem[0] = 32'h0001_0001; mem[1] = 32'h4501_4505;
    reset = 1'b0;
    wait_acc("t2_timeout", 4, 20);
    chk("t2_i0", acc_instr[0], 32'h0000_0001); chk("t2_pc0", acc_pc[0], 32'h0);
    chk("t2_i1", acc_instr[1], 32'h0000_0001); chk("t2_pc1", acc_pc[1], 32'h2);
    chk("t2_i2", acc_instr[2], 32'h0000_4505); chk("t2_pc2", acc_pc[2], 32'h4);
    chk("t2_i3", acc_instr[3], 32'h0000_4501); chk("t2_pc3", acc_pc[3], 32'h6);
    chk("t2_comp", 32'({acc_comp[0], acc_comp[1], acc_comp[2], acc_comp[3]}), 32'hF);
    for (int i = 0; i < 3; i++) chk("t2_b2b", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd1);

    // Straddling 32-bit instruction.
    begin_test();
    mem[0] = 32'h0093_4501; mem[1] = 32'h0013_0010;
    reset = 1'b0;
    wait_acc("t3_timeout", 3, 20);
    chk("t3_i0", acc_instr[0], 32'h0000_4501); chk("t3_c0", 32'(acc_comp[0]), 32'd1);
    chk("t3_i1", acc_instr[1], 32'h0010_0093); chk("t3_pc1", acc_pc[1], 32'h2);
    chk("t3_c1", 32'(acc_comp[1]), 32'd0);
    chk("t3_i2", acc_instr[2], 32'h0000_0013); chk("t3_pc2", acc_pc[2], 32'h6);

    // Redirect to an odd halfword while a read is in flight.
    begin_test();
    mem[0] = 32'h0001_0001; mem[1] = 32'h4501_4505;
    mem[2] = 32'h4515_0000; mem[3] = 32'h0000_0001;
    reset = 1'b0;
    step();
    step();
    chk("t4_valid_r", 32'(bus.out_valid), 32'd1);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_000B;
    step();
    bus.redirect = 1'b0;
    chk("t4_valid_r1", 32'(bus.out_valid), 32'd0);
    chk("t4_addr_r1", 32'(bus.imem_addr), 32'd2);
    step();
    chk("t4_valid_r2", 32'(bus.out_valid), 32'd0);
    step();
    chk("t4_valid_r3", 32'(bus.out_valid), 32'd1);
    chk("t4_pc_r3", bus.out_pc, 32'h0000_000A);
    chk("t4_instr_r3", bus.out_instr, 32'h0000_4515);
    chk("t4_no_pop", 32'(acc_pc.size()), 32'd0);
    wait_acc("t4_timeout", 3, 20);
    chk("t4_pc1", acc_pc[1], 32'hC); chk("t4_i1", acc_instr[1], 32'h0000_0001);
    chk("t4_pc2", acc_pc[2], 32'hE); chk("t4_i2", acc_instr[2], 32'h0000_0000);

    // Backpressure on a compressed stream.
    begin_test();
    for (int i = 0; i < 16; i++) mem[i] = {hwn(2*i+1), hwn(2*i)};
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus.out_ready = 1'b0;
    snap_pc = bus.out_pc; snap_instr = bus.out_instr;
    chk("t5_valid_stall", 32'(bus.out_valid), 32'd1);
    snap_addr = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t5_hold_pc", bus.out_pc, snap_pc);
      chk("t5_hold_instr", bus.out_instr, snap_instr);
      if (i == 4) snap_addr = bus.imem_addr;
      if (i > 4) chk("t5_issue_stopped", 32'(bus.imem_addr), 32'(snap_addr));
    end
    n0 = acc_pc.size();
    bus.out_ready = 1'b1;
    wait_acc("t5_timeout", n0 + 8, 30);
    for (int i = 0; i + 1 < acc_pc.size(); i++)
      chk("t5_pc_step", acc_pc[i+1], acc_pc[i] + 32'd2);
    for (int i = 0; i < acc_pc.size(); i++)
      chk("t5_instr", acc_instr[i], {16'h0, hwn(int'(acc_pc[i] >> 1))});

    // Asynchronous reset mid-stream with a read in flight.
    begin_test();
    for (int i = 0; i < 16; i++) mem[i] = {hwn(2*i+1), hwn(2*i)};
    reset = 1'b0;
    step();
    step();
    chk("t6_valid_pre", 32'(bus.out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_async_pc", bus.out_pc, RPC);
    step();
    clear_acc();
    reset = 1'b0;
    step();
    step();
    chk("t6_valid_c2", 32'(bus.out_valid), 32'd1);
    chk("t6_pc_c2", bus.out_pc, 32'h0);
    chk("t6_instr_c2", bus.out_instr, 32'h0000_0001);
    wait_acc("t6_timeout", 3, 20);
    chk("t6_pc2", acc_pc[2], 32'h4);
    chk("t6_i2", acc_instr[2], 32'h0000_0009);

    // Word-address wrap after a redirect to the last halfword of imem.
    begin_test();
    mem[(1<<AW)-1] = 32'h4515_0001; mem[0] = 32'h0000_0009;
    reset = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_1FFE;
    step();
    bus.redirect = 1'b0;
    chk("t7_addr_last", 32'(bus.imem_addr), 32'h7FF);
    step();
    chk("t7_addr_wrap", 32'(bus.imem_addr), 32'd0);
    step();
    chk("t7_valid", 32'(bus.out_valid), 32'd1);
    wait_acc("t7_timeout", 2, 20);
    chk("t7_pc0", acc_pc[0], 32'h0000_1FFE); chk("t7_i0", acc_instr[0], 32'h0000_4515);
    chk("t7_pc1", acc_pc[1], 32'h0000_2000); chk("t7_i1", acc_instr[1], 32'h0000_0009);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
